// File: rtl/cam_frame_writer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cam_frame_writer_pkg : shared states, defaults and RGB444 byte layout       |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
package cam_frame_writer_pkg;

    localparam int H_IN_DEFAULT = 640;
    localparam int V_IN_DEFAULT = 480;
    localparam int PIX_W        = 12;
    localparam int CNT_W        = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_ACTIVE = 2'd2
    } cam_state_e;

    // First byte carries R in d[3:0]; second byte carries G in d[7:4], B in d[3:0].
    function automatic logic [PIX_W-1:0] rgb444_pixel(input logic [3:0] red, input logic [7:0] gb);
        return {red, gb[7:4], gb[3:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_frame_writer_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cam_frame_writer_sync_edge : multi-flop synchronizer with rise/fall pulses  |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module cam_frame_writer_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        chain_d = (chain_q << 1) | STAGES'(async_in);
        prev_d  = chain_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign level = chain_q[STAGES-1];
    assign rise  = chain_q[STAGES-1] & ~prev_q;
    assign fall  = ~chain_q[STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/cam_frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cam_frame_writer : oversampled camera capture, 2:1 decimation, buffer write |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module cam_frame_writer
    import cam_frame_writer_pkg::*;
#(
    parameter int H_IN    = H_IN_DEFAULT,
    parameter int V_IN    = V_IN_DEFAULT,
    parameter int DEC_SH  = 1,
    parameter int ADDR_W  = 17,
    parameter int SYNC_FF = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_d,
    input  logic              capture_en,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [11:0]       buf_din,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic              ovf_err
);

    localparam int EXT_W = ADDR_W + 1;
    localparam int c_row_words   = H_IN >> DEC_SH;
    localparam int c_frame_words = (H_IN * V_IN) >> (2 * DEC_SH);
    localparam logic [CNT_W-1:0] c_dec_mask = CNT_W'((1 << DEC_SH) - 1);

    logic w_pclk_lvl, w_pclk_rise, w_pclk_fall;
    logic w_vsync_lvl, w_vsync_rise, w_vsync_fall;
    logic w_href_lvl, w_href_rise, w_href_fall;
    logic w_unused;

    // pclk and href get one extra stage so they line up with the delayed data byte.
    cam_frame_writer_sync_edge #(.STAGES(SYNC_FF + 1)) u_sync_pclk (
        .clk(clk), .resetn(resetn), .async_in(cam_pclk),
        .level(w_pclk_lvl), .rise(w_pclk_rise), .fall(w_pclk_fall)
    );
    cam_frame_writer_sync_edge #(.STAGES(SYNC_FF)) u_sync_vsync (
        .clk(clk), .resetn(resetn), .async_in(cam_vsync),
        .level(w_vsync_lvl), .rise(w_vsync_rise), .fall(w_vsync_fall)
    );
    cam_frame_writer_sync_edge #(.STAGES(SYNC_FF + 1)) u_sync_href (
        .clk(clk), .resetn(resetn), .async_in(cam_href),
        .level(w_href_lvl), .rise(w_href_rise), .fall(w_href_fall)
    );
    assign w_unused = &{1'b0, w_pclk_lvl, w_pclk_fall, w_vsync_lvl};

    logic [SYNC_FF:0][7:0] d_pipe_q, d_pipe_d;
    logic [7:0]            w_d_sync;

    cam_state_e        state_q, state_d;
    logic              phase_q, phase_d;
    logic [3:0]        red_q, red_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  line_q, line_d;
    logic [EXT_W-1:0]  row_base_q, row_base_d;
    logic              buf_we_q, buf_we_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [11:0]       buf_din_q, buf_din_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              ovf_err_q, ovf_err_d;

    logic              w_phase_eff;
    logic [CNT_W-1:0]  w_col_half;
    logic [EXT_W-1:0]  w_addr_ext;
    logic              w_keep;

    assign w_d_sync = d_pipe_q[SYNC_FF];

    always_comb begin
        d_pipe_d     = {d_pipe_q[SYNC_FF-1:0], cam_d};
        w_phase_eff  = w_href_rise ? 1'b0 : phase_q;
        w_col_half   = col_q >> DEC_SH;
        w_addr_ext   = row_base_q + EXT_W'(w_col_half);
        w_keep       = ((col_q & c_dec_mask) == '0) && ((line_q & c_dec_mask) == '0)
                       && (w_col_half < CNT_W'(c_row_words));
        state_d      = state_q;
        phase_d      = phase_q;
        red_d        = red_q;
        col_d        = col_q;
        line_d       = line_q;
        row_base_d   = row_base_q;
        buf_we_d     = 1'b0;
        buf_addr_d   = buf_addr_q;
        buf_din_d    = buf_din_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        ovf_err_d    = ovf_err_q;

        case (state_q)
            S_IDLE: begin
                if (capture_en && w_vsync_rise) state_d = S_ARM;
            end
            S_ARM: begin
                if (w_vsync_fall) begin
                    state_d    = S_ACTIVE;
                    col_d      = '0;
                    line_d     = '0;
                    row_base_d = '0;
                    phase_d    = 1'b0;
                end
            end
            S_ACTIVE: begin
                if (w_vsync_rise) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    state_d      = capture_en ? S_ARM : S_IDLE;
                end else if (w_href_fall) begin
                    col_d   = '0;
                    phase_d = 1'b0;
                    // row_base saturates once past the frame so the address math cannot wrap
                    if (((line_q & c_dec_mask) == '0) && (row_base_q < EXT_W'(c_frame_words)))
                        row_base_d = row_base_q + EXT_W'(c_row_words);
                    if (line_q != '1) line_d = line_q + 1'b1;
                end else begin
                    if (w_href_rise) phase_d = 1'b0;
                    if (w_pclk_rise && w_href_lvl) begin
                        if (!w_phase_eff) begin
                            red_d   = w_d_sync[3:0];
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (col_q != '1) col_d = col_q + 1'b1;
                            if (w_keep) begin
                                if (w_addr_ext >= EXT_W'(c_frame_words)) begin
                                    ovf_err_d = 1'b1;
                                end else begin
                                    buf_we_d   = 1'b1;
                                    buf_addr_d = w_addr_ext[ADDR_W-1:0];
                                    buf_din_d  = rgb444_pixel(red_q, w_d_sync);
                                end
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            d_pipe_q     <= '0;
            state_q      <= S_IDLE;
            phase_q      <= 1'b0;
            red_q        <= '0;
            col_q        <= '0;
            line_q       <= '0;
            row_base_q   <= '0;
            buf_we_q     <= 1'b0;
            buf_addr_q   <= '0;
            buf_din_q    <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            ovf_err_q    <= 1'b0;
        end else begin
            d_pipe_q     <= d_pipe_d;
            state_q      <= state_d;
            phase_q      <= phase_d;
            red_q        <= red_d;
            col_q        <= col_d;
            line_q       <= line_d;
            row_base_q   <= row_base_d;
            buf_we_q     <= buf_we_d;
            buf_addr_q   <= buf_addr_d;
            buf_din_q    <= buf_din_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            ovf_err_q    <= ovf_err_d;
        end
    end

    assign buf_we     = buf_we_q;
    assign buf_addr   = buf_addr_q;
    assign buf_din    = buf_din_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == S_ARM) || (state_q == S_ACTIVE);
    assign frame_cnt  = frame_cnt_q;
    assign ovf_err    = ovf_err_q;

endmodule
`default_nettype wire
